// File: rtl/usb_rx_ctrl_param.sv
// rtl/usb_rx_ctrl_param.sv - USB receive control FSM: SYNC check, byte strobes, length bound, errors.
// Optional PID complement check enabled by defining RCU_PID_CHECK_EN.
module usb_rx_ctrl_param #(
    parameter int                DATA_W       = 8,
    parameter logic [DATA_W-1:0] SYNC_PATTERN = 8'h80,
    parameter int                MAX_BYTES    = 64,
    parameter int                CNT_W        = 7
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              d_edge,
    input  logic              eop,
    input  logic              shift_enable,
    input  logic [DATA_W-1:0] rcv_data,
    input  logic              byte_received,
    output logic              rcving,
    output logic              w_enable,
    output logic              r_error,
    output logic              pkt_done,
    output logic [CNT_W-1:0]  byte_count
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE, RCV_SYNC, CMP_SYNC, RCV_BYTE, STORE, EOP_WAIT, ERR_WAIT, EIDLE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   r_byte_count;
    logic               r_rcving;
    logic               r_w_enable;
    logic               r_err;
    logic               r_pkt_done;
    logic               w_eop_s;
    logic               w_pid_bad;

    assign w_eop_s = eop & shift_enable;

`ifdef RCU_PID_CHECK_EN
    // Set while the next byte is the PID, i.e. the first byte after SYNC.
    logic r_pid_pend;
    assign w_pid_bad = r_pid_pend & (rcv_data[7:4] != ~rcv_data[3:0]);
`else
    assign w_pid_bad = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (d_edge) w_next = RCV_SYNC;
            RCV_SYNC: begin
                if (byte_received)  w_next = CMP_SYNC;
                else if (w_eop_s)   w_next = ERR_WAIT;
            end
            CMP_SYNC: w_next = (rcv_data == SYNC_PATTERN) ? RCV_BYTE : ERR_WAIT;
            RCV_BYTE: begin
                // A completed byte wins over EOP in the same clock; EOP is seen again next bit.
                if (byte_received)  w_next = w_pid_bad ? ERR_WAIT : STORE;
                else if (w_eop_s)   w_next = (r_bit_cnt == '0) ? EOP_WAIT : ERR_WAIT;
            end
            STORE:    w_next = (r_byte_count == CNT_W'(MAX_BYTES)) ? ERR_WAIT : RCV_BYTE;
            EOP_WAIT: if (d_edge) w_next = IDLE;
            ERR_WAIT: if (w_eop_s) w_next = EIDLE;
            EIDLE:    if (d_edge) w_next = RCV_SYNC;
            default:  w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_byte_count <= '0;
            r_rcving     <= 1'b0;
            r_w_enable   <= 1'b0;
            r_err        <= 1'b0;
            r_pkt_done   <= 1'b0;
`ifdef RCU_PID_CHECK_EN
            r_pid_pend   <= 1'b0;
`endif
        end else begin
            r_state    <= w_next;
            r_rcving   <= (w_next != IDLE) && (w_next != EIDLE);
            r_w_enable <= (w_next == STORE);
            r_err      <= (w_next == ERR_WAIT) || (w_next == EIDLE);
            r_pkt_done <= (r_state == EOP_WAIT) && (w_next == IDLE);

            if (w_next == RCV_SYNC && r_state != RCV_SYNC)
                r_byte_count <= '0;
            else if (w_next == STORE && r_byte_count != {CNT_W{1'b1}})
                r_byte_count <= r_byte_count + 1'b1;

            if (byte_received || (w_next == RCV_BYTE && r_state != RCV_BYTE))
                r_bit_cnt <= '0;
            else if (r_state == RCV_BYTE && shift_enable)
                r_bit_cnt <= r_bit_cnt + 1'b1;

`ifdef RCU_PID_CHECK_EN
            if (r_state == CMP_SYNC)
                r_pid_pend <= 1'b1;
            else if (r_state == RCV_BYTE && byte_received)
                r_pid_pend <= 1'b0;
`endif
        end
    end

    assign rcving     = r_rcving;
    assign w_enable   = r_w_enable;
    assign r_error    = r_err;
    assign pkt_done   = r_pkt_done;
    assign byte_count = r_byte_count;
endmodule

// File: tb/tb_usb_rx_ctrl_param.sv
// tb/tb_usb_rx_ctrl_param.sv - scoreboard bench for usb_rx_ctrl_param with MAX_BYTES=4.
module tb_usb_rx_ctrl_param;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       d_edge = 1'b0;
    logic       eop = 1'b0;
    logic       shift_enable = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       byte_received = 1'b0;
    logic       rcving, w_enable, r_error, pkt_done;
    logic [6:0] byte_count;

    int checks = 0;
    int failures = 0;

    typedef struct packed { logic [7:0] d; logic [6:0] c; } wr_t;
    wr_t        exp_wr[$];
    logic [6:0] exp_done[$];

    usb_rx_ctrl_param #(.DATA_W(8), .SYNC_PATTERN(8'h80), .MAX_BYTES(4), .CNT_W(7)) dut (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
        .rcv_data(rcv_data), .byte_received(byte_received), .rcving(rcving),
        .w_enable(w_enable), .r_error(r_error), .pkt_done(pkt_done), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write and packet-done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (n_rst) begin
            if (w_enable) begin
                if (exp_wr.size() == 0) check("unexpected_write", {17'b0, rcv_data, byte_count}, 32'h0);
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("write_data", {24'b0, rcv_data}, {24'b0, e.d});
                    check("write_count", {25'b0, byte_count}, {25'b0, e.c});
                end
            end
            if (pkt_done) begin
                if (exp_done.size() == 0) check("unexpected_pkt_done", 32'd1, 32'd0);
                else begin
                    logic [6:0] c;
                    c = exp_done.pop_front();
                    check("done_count", {25'b0, byte_count}, {25'b0, c});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_edge();
        d_edge = 1'b1; tick(); d_edge = 1'b0; tick();
    endtask

    task automatic send_bit(input logic e);
        eop = e; shift_enable = 1'b1; tick(); shift_enable = 1'b0; tick();
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        rcv_data = d; byte_received = 1'b1; tick(); byte_received = 1'b0; tick(); tick();
    endtask

    task automatic push_wr(input logic [7:0] d, input logic [6:0] c);
        wr_t e;
        e.d = d; e.c = c;
        exp_wr.push_back(e);
    endtask

    task automatic drained(input string name);
        tick(); tick();
        check({name, "_writes_left"}, exp_wr.size(), 0);
        check({name, "_done_left"}, exp_done.size(), 0);
    endtask

    initial begin
        tick(); tick();
        check("rst_rcving", rcving, 0);
        check("rst_w_enable", w_enable, 0);
        check("rst_r_error", r_error, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_byte_count", byte_count, 0);
        n_rst = 1'b1; tick();

        // Clean two-byte packet ending on a byte boundary.
        pulse_edge();
        check("s1_rcving", rcving, 1);
        send_byte(8'h80);
        push_wr(8'hA5, 7'd1); send_byte(8'hA5);
        push_wr(8'h3C, 7'd2); send_byte(8'h3C);
        send_bit(1'b1); send_bit(1'b1);
        check("s1_eop_wait_rcving", rcving, 1);
        eop = 1'b0;
        exp_done.push_back(7'd2);
        pulse_edge();
        drained("s1");
        check("s1_byte_count", byte_count, 2);
        check("s1_r_error", r_error, 0);
        check("s1_rcving_idle", rcving, 0);

        // Bad SYNC byte.
        pulse_edge();
        send_byte(8'h81);
        check("s2_err_wait_error", r_error, 1);
        check("s2_err_wait_rcving", rcving, 1);
        send_bit(1'b1); eop = 1'b0;
        check("s2_eidle_error", r_error, 1);
        check("s2_eidle_rcving", rcving, 0);
        pulse_edge();
        check("s2_restart_error", r_error, 0);
        check("s2_restart_rcving", rcving, 1);

        // EOP after three bits of a byte (continues from RCV_SYNC).
        send_byte(8'h80);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1);
        check("s3_partial_error", r_error, 1);
        check("s3_partial_count", byte_count, 0);
        send_bit(1'b1); eop = 1'b0;
        check("s3_eidle_rcving", rcving, 0);
        drained("s3");

        // Overflow: six bytes with MAX_BYTES=4.
        pulse_edge();
        send_byte(8'h80);
        push_wr(8'h11, 7'd1); send_byte(8'h11);
        push_wr(8'h22, 7'd2); send_byte(8'h22);
        push_wr(8'h33, 7'd3); send_byte(8'h33);
        push_wr(8'h44, 7'd4); send_byte(8'h44);
        check("s4_overflow_error", r_error, 1);
        send_byte(8'h55);
        send_byte(8'h66);
        send_bit(1'b1); eop = 1'b0;
        pulse_edge();
        drained("s4");
        check("s4_count_cleared_on_restart", byte_count, 0);

        // PID byte 0xE2 (fails the complement check when enabled).
        send_byte(8'h80);
`ifdef RCU_PID_CHECK_EN
        send_byte(8'hE2);
        check("s5_pid_error", r_error, 1);
        send_byte(8'h11);
        send_bit(1'b1); eop = 1'b0;
        check("s5_pid_count", byte_count, 0);
        pulse_edge();
`else
        push_wr(8'hE2, 7'd1); send_byte(8'hE2);
        push_wr(8'h11, 7'd2); send_byte(8'h11);
        send_bit(1'b1); eop = 1'b0;
        check("s5_no_pid_error", r_error, 0);
        exp_done.push_back(7'd2);
        pulse_edge();
        pulse_edge();
`endif
        drained("s5");

        // Asynchronous reset mid-byte, then a clean restart.
        send_byte(8'h80);
        push_wr(8'h9C, 7'd1); send_byte(8'h9C);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        check("s6_pre_reset_count", byte_count, 1);
        n_rst = 1'b0; #1;
        check("s6_async_rcving", rcving, 0);
        check("s6_async_count", byte_count, 0);
        check("s6_async_error", r_error, 0);
        check("s6_async_wen", w_enable, 0);
        tick(); n_rst = 1'b1; tick();
        pulse_edge();
        send_byte(8'h80);
        push_wr(8'h5A, 7'd1); send_byte(8'h5A);
        send_bit(1'b1); eop = 1'b0;
        exp_done.push_back(7'd1);
        pulse_edge();
        drained("s6");
        check("s6_final_count", byte_count, 1);
        check("s6_final_error", r_error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
